// File: rtl/pipeline_pkg.sv
// Shared pipeline types: skid buffer state encoding and occupancy helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

  // Occupancy implied by each state; the unused encoding reads as empty.
  function automatic logic [1:0] state_count(input skid_state_t s);
    logic [1:0] c;
    case (s)
      BUSY:    c = 2'd1;
      FULL:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/data_register.sv
// One word of storage with load enable and synchronous clear.
module data_register #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [NBits-1:0] d,
  output logic [NBits-1:0] q
);

  // Clear wins over load so a squash can never be undone by a same-cycle write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/pipeline_skid_register.sv
// Elastic stage register: main entry drives the output, skid entry absorbs the
// word that arrives in the cycle downstream stalls, so In_Ready can be registered.
//
//  state | meaning
//  EMPTY | no word held, Out_Valid low
//  BUSY  | main holds the output word
//  FULL  | main holds output word, skid holds the next one, In_Ready low
module pipeline_skid_register
  import pipeline_pkg::*;
#(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [NBits-1:0] In_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [NBits-1:0] Out_Data,
  output logic [1:0]       Count
);

  skid_state_t      state, state_next;
  logic             in_fire, out_fire;
  logic             main_load, skid_load;
  logic [NBits-1:0] main_d, main_q, skid_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  // Next-state decode; a flush empties the stage regardless of handshakes.
  always_comb begin
    state_next = state;
    if (Flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_next = BUSY;
        BUSY: begin
          if (in_fire && !out_fire)      state_next = FULL;
          else if (!in_fire && out_fire) state_next = EMPTY;
        end
        FULL:    if (out_fire) state_next = BUSY;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Handshake outputs and register load controls, all decoded from state.
  always_comb begin
    In_Ready  = (state != FULL);
    Out_Valid = (state != EMPTY);
    Count     = state_count(state);
    in_fire   = In_Valid && In_Ready;
    out_fire  = Out_Valid && Out_Ready;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = In_Data;
    case (state)
      EMPTY: main_load = in_fire;
      BUSY: begin
        main_load = in_fire && out_fire;
        skid_load = in_fire && !out_fire;
      end
      FULL: begin
        main_load = out_fire;
        main_d    = skid_q;
      end
      default: ;
    endcase
  end

  data_register #(.NBits(NBits)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (Flush),
    .d     (main_d),
    .q     (main_q)
  );

  data_register #(.NBits(NBits)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (Flush),
    .d     (In_Data),
    .q     (skid_q)
  );

  assign Out_Data = main_q;

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Scoreboard bench: driver pushes accepted words, monitor pops on each output transfer.
module tb_pipeline_skid_register;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Flush = 1'b0;
  logic         In_Valid = 1'b0;
  logic [W-1:0] In_Data = '0;
  logic         Out_Ready = 1'b0;
  logic         In_Ready;
  logic         Out_Valid;
  logic [W-1:0] Out_Data;
  logic [1:0]   Count;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] exp_q[$];
  bit           accept_pending = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  pipeline_skid_register #(.NBits(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Count     (Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the reference FIFO contents at every falling edge.
  initial begin
    forever begin
      int n;
      @(negedge clk);
      n = exp_q.size();
      if (!reset) begin
        exp_q.delete();
        accept_pending = 1'b0;
        prev_stall = 1'b0;
        check("rst_out_valid", W'(Out_Valid), W'(0));
        check("rst_in_ready", W'(In_Ready), W'(1));
        check("rst_count", W'(Count), W'(0));
        check("rst_out_data", Out_Data, W'(0));
      end else begin
        check("out_valid", W'(Out_Valid), W'(n > 0));
        check("in_ready", W'(In_Ready), W'(n < 2));
        check("count", W'(Count), W'(n));
        if (prev_stall) check("stall_stable", Out_Data, prev_data);
        if (n > 0 && Out_Ready) begin
          check("out_data", Out_Data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        prev_stall = (n > 0) && !Out_Ready && !Flush;
        prev_data = Out_Data;
        accept_pending = In_Valid && (n < 2) && !Flush;
        if (Flush) exp_q.delete();
      end
    end
  end

  // Driver: records the word accepted at the last edge, then applies new inputs.
  task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    @(posedge clk);
    #1;
    if (accept_pending && reset) exp_q.push_back(In_Data);
    accept_pending = 1'b0;
    In_Valid = v;
    In_Data = d;
    Out_Ready = r;
    Flush = f;
  endtask

  initial begin
    // reset held with a word offered
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // back-to-back streaming
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    step(1'b1, 32'h3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // backpressure fill and drain
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("bp_count", W'(Count), W'(2));
    check("bp_in_ready", W'(In_Ready), W'(0));
    step(1'b1, 32'hC, 1'b1, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // flush while full with a word offered
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("flush_out_valid", W'(Out_Valid), W'(0));
    check("flush_count", W'(Count), W'(0));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset while full, between clock edges
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("pre_async_count", W'(Count), W'(2));
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_out_valid", W'(Out_Valid), W'(0));
    check("async_count", W'(Count), W'(0));
    check("async_in_ready", W'(In_Ready), W'(1));
    step(1'b0, '0, 1'b1, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // random valid/ready/flush, 8-bit data, ready bias varied per segment
    for (int i = 0; i < 10000; i++) begin
      int      seg;
      bit      v, r, f;
      seg = (i / 1000) % 3;
      v = ($urandom % 4) != 0;
      r = (seg == 0) ? (($urandom % 4) != 0) :
          (seg == 1) ? (($urandom % 4) == 0) : (($urandom % 2) == 0);
      f = ($urandom % 64) == 0;
      step(v, W'($urandom & 32'hFF), r, f);
    end
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("drain_empty", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
